// File: rtl/enc_pkg.sv
// Shared types and sizing for the 32-to-5 sequential index encoder.
package enc_pkg;

  localparam int WIDTH = 32;
  localparam int IDXW  = $clog2(WIDTH);

  typedef enum logic {IDLE, DRAIN} enc_state_t;
  typedef logic [WIDTH-1:0] mask_t;
  typedef logic [IDXW-1:0]  idx_t;

endpackage

// File: rtl/enc32to5_if.sv
// Mask-in / index-out handshake bundle; the producer/consumer side is master, the encoder is slave.
interface enc32to5_if;
  import enc_pkg::*;

  logic  in_valid;
  logic  in_ready;
  mask_t in_mask;
  logic  out_valid;
  logic  out_ready;
  idx_t  out_idx;
  logic  out_last;
  logic  busy;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_idx, out_last, busy
  );

endinterface

// File: rtl/lsb_enc32to5.sv
// Combinational lowest-set-bit encoder; one_hot_o flags a mask holding exactly one set bit.
module lsb_enc32to5
  import enc_pkg::*;
(
  input  mask_t mask_i,
  output idx_t  idx_o,
  output logic  one_hot_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o = '0;
    // Scanning downward lets the lowest set bit be the last (winning) assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = idx_t'(i);
    end
  end

  assign one_hot_o = (mask_i != '0) && ((mask_i & (mask_i - mask_t'(1))) == '0);

endmodule

// File: rtl/enc32to5.sv
// Sequential 32-to-5 index encoder: accepts a mask, then emits each set bit's index in ascending order.
module enc32to5
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  enc32to5_if.slave  bus
);

  enc_state_t state_q, state_d;
  mask_t      pend_q, pend_d;
  idx_t       lsb_idx;
  logic       lsb_one_hot;

  lsb_enc32to5 u_lsb (
    .mask_i    (pend_q),
    .idx_o     (lsb_idx),
    .one_hot_o (lsb_one_hot)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        // A zero mask is accepted and dropped without leaving IDLE.
        if (bus.in_valid && bus.in_mask != '0) begin
          pend_d  = bus.in_mask;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          pend_d = pend_q & ~(mask_t'(1) << lsb_idx);
          if (lsb_one_hot) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs come only from registered state, so reset clears them without a clock edge.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q == DRAIN);
  assign bus.out_idx   = lsb_idx;
  assign bus.out_last  = lsb_one_hot;

endmodule

// File: tb/tb_enc32to5.sv
// Self-checking bench for enc32to5: directed boundary masks plus random masks with random backpressure.
module tb_enc32to5;
  import enc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  enc32to5_if bus ();

  enc32to5 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected idle-state outputs after reset or after a mask has drained.
  task automatic check_idle(input string tag);
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready: got %b want 1", tag, bus.in_ready);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s out_valid: got %b want 0", tag, bus.out_valid);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: got %b want 0", tag, bus.busy);
    end
    n_cmp++;
  endtask

  // Feed one mask, then walk every beat against an index list built from the mask bits.
  // ready_mode: 0 = always ready, 1 = random ready, 2 = ready held low for the first 3 cycles.
  task automatic run_mask(input mask_t m, input int ready_mode, input string tag);
    int    exp_q[$];
    int    n_bits;
    int    cyc;
    mask_t recon;
    for (int i = 0; i < WIDTH; i++) if (m[i]) exp_q.push_back(i);
    n_bits = exp_q.size();
    recon  = '0;
    cyc    = 0;

    check_idle({tag, "/pre"});
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    while (exp_q.size() > 0 && cyc < 400) begin
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc >= 3);
      endcase
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_mask  = mask_t'($urandom);

      if (bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL %s out_valid c%0d: got %b want 1", tag, cyc, bus.out_valid);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL %s in_ready/busy c%0d: got %b/%b want 0/1", tag, cyc, bus.in_ready, bus.busy);
      end
      n_cmp++;
      if (bus.out_idx !== idx_t'(exp_q[0])) begin
        n_fail++; $display("FAIL %s out_idx c%0d: got %0d want %0d", tag, cyc, bus.out_idx, exp_q[0]);
      end
      n_cmp++;
      if (bus.out_last !== 1'(exp_q.size() == 1)) begin
        n_fail++; $display("FAIL %s out_last c%0d: got %b want %b", tag, cyc, bus.out_last, exp_q.size() == 1);
      end
      n_cmp++;

      if (bus.out_ready) begin
        // Decode the index back to a one-hot select, as the 5-to-32 decoder path would.
        recon = recon | (mask_t'(1) << bus.out_idx);
        void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (exp_q.size() > 0) begin
      n_fail++; $display("FAIL %s timeout: %0d beats outstanding", tag, exp_q.size());
    end
    n_cmp++;
    check_idle({tag, "/post"});
    if (recon !== m) begin
      n_fail++; $display("FAIL %s decoded mask: got %h want %h", tag, recon, m);
    end
    n_cmp++;
    if (ready_mode == 0) begin
      if (cyc + 1 !== n_bits + 1) begin
        n_fail++; $display("FAIL %s cycles: got %0d want %0d", tag, cyc + 1, n_bits + 1);
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b0;
    #3;
    check_idle("reset");
    if (bus.out_idx !== '0 || bus.out_last !== 1'b0) begin
      n_fail++; $display("FAIL reset idx/last: got %0d/%b want 0/0", bus.out_idx, bus.out_last);
    end
    n_cmp++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_mask();
    bus.in_valid = 1'b1;
    bus.in_mask  = '0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_idle($sformatf("zero_mask/c%0d", i));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_drain();
    bus.in_valid  = 1'b1;
    bus.in_mask   = 32'h0000_F0F0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== idx_t'(5)) begin
      n_fail++; $display("FAIL mid_drain setup: valid %b idx %0d want 1 5", bus.out_valid, bus.out_idx);
    end
    n_cmp++;
    #2 rst_n = 1'b0;
    #1;
    check_idle("mid_drain_rst");
    if (bus.out_idx !== '0 || bus.out_last !== 1'b0) begin
      n_fail++; $display("FAIL mid_drain_rst idx/last: got %0d/%b want 0/0", bus.out_idx, bus.out_last);
    end
    n_cmp++;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after_rst");
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      mask_t m;
      m = mask_t'($urandom);
      if (k % 3 == 0) m = m & mask_t'($urandom);
      if (m == '0) m = mask_t'(1) << $urandom_range(0, WIDTH - 1);
      run_mask(m, 1, $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    run_mask(32'h0000_0001, 0, "bit0");
    run_mask(32'h8000_0000, 0, "bit31");
    run_mask(32'h8000_0011, 0, "three_bits");
    run_mask(32'h0000_0300, 2, "backpressure");
    test_zero_mask();
    run_mask(32'hFFFF_FFFF, 0, "all_ones");
    run_mask(32'h0000_0006, 0, "back_to_back_a");
    run_mask(32'h4000_0000, 0, "back_to_back_b");
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/enc32to5.md
# enc32to5

Sequential 32-to-5 index encoder: the inverse of the 5-to-32 register-select decoder. It accepts a 32-bit mask, such as a register-file dirty or pending mask, over a valid/ready handshake. It then emits the 5-bit index of every set bit, in ascending order, one index per handshake beat. Downstream CPU logic uses it to walk register masks, for example for writeback replay, scoreboard flush or debug dump, and feeds each index back into the decoder path.

## Interface
Parameters:
- WIDTH, 32, mask width; must be a power of two.
- IDXW, $clog2(WIDTH) = 5, index width.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_mask is valid.
- in_ready  output  1  block can accept a mask; high only in IDLE.
- in_mask  input  WIDTH  mask to be encoded.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  IDXW  index of the lowest remaining set bit.
- out_last  output  1  the current beat is the final set bit of the mask.
- busy  output  1  state is DRAIN.

## Operation
- States: IDLE, DRAIN. The mask register is pend[WIDTH-1:0].
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready with in_mask != 0: pend <= in_mask, go to DRAIN.
  - With in_mask == 0: the mask is accepted and dropped; no beat is produced and the state stays IDLE.
- DRAIN:
  - out_valid=1.
  - out_idx = index of the lowest set bit of pend.
  - out_last = (pend has exactly one bit set).
  - in_ready=0.
- Beat transfer is out_valid && out_ready. On a transfer the bit at out_idx is cleared in pend. If out_last was 1, go to IDLE.
- With out_ready=0: out_idx, out_last and pend hold stable. out_valid is never withdrawn once raised.
- All outputs derive only from registered state (state, pend). There is no combinational path from any input to any output.
- A mask with N set bits produces exactly N beats. Indices are strictly increasing, and out_last is asserted on the Nth beat only.
- in_mask is sampled only on acceptance. Changes on in_mask during DRAIN are ignored.
- Reset values: state=IDLE, pend=0, out_valid=0, out_idx=0, out_last=0, busy=0, in_ready=1.

## Timing
- Latency: the first out_valid is in the cycle after the accept edge.
- Throughput: one beat per cycle while out_ready=1. A full mask takes N+1 cycles, counting accept plus N beats.
- There is no overlap between masks. in_ready goes high in the cycle after the last beat transfers, so back-to-back masks have one IDLE cycle between them.
- rst_n asserted mid-DRAIN: outputs go to their reset values immediately, without waiting for a clock edge. Remaining bits are discarded and no partial beat is replayed.
- Reset deassertion is assumed synchronised upstream. The first accept can occur on the first rising edge with rst_n=1.
- Boundary masks:
  - bit 0 only gives a single beat, idx 0, last=1.
  - bit 31 only gives a single beat, idx 31, last=1.
  - 0xFFFF_FFFF gives 32 beats, 0..31.

## Structure
- Shared package enc_pkg holds:
  - WIDTH/IDXW localparams;
  - typedef enum logic {IDLE, DRAIN} enc_state_t;
  - typedef logic [WIDTH-1:0] mask_t;
  - typedef logic [IDXW-1:0] idx_t.
- Sub-module lsb_enc32to5 is combinational: input mask_t, outputs idx_t index of the lowest set bit plus a one_hot flag. The flag is computed as mask & (mask-1) == 0 and mask != 0. The top level uses it for out_idx and out_last.
- The top level holds the FSM, the pend register and the clear-bit logic: pend & ~(1 << out_idx).

## Test plan
- Reset: hold rst_n=0 → in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0. Then assert rst_n=0 asynchronously mid-cycle during DRAIN → out_valid=0 immediately.
- in_mask=0x0000_0001, out_ready=1 → one beat next cycle: idx=0, last=1; IDLE the cycle after.
- in_mask=0x8000_0011, out_ready=1 → beats idx 4'h0, 4, 31 on consecutive cycles; last=1 only with idx=31.
- in_mask=0x0000_0300, out_ready low for 3 cycles → idx=8 held stable with out_valid=1. Then out_ready=1 → idx 8, then 9 with last=1.
- in_mask=0 → accepted with no out_valid ever raised; in_ready stays 1.
- in_mask=0xFFFF_FFFF, out_ready=1 → 32 beats, idx 0..31 ascending, 33 cycles total. Each idx passed through dec5to32 must reproduce exactly one bit of the original mask.
